gradient_outlet_scanner: RTL

//  Reads back the outlet stage of the 2-inlet/7-outlet gradient generator. Steps a one-hot

---
 rtl/gradient_scan_pkg.sv | 21 ++
 rtl/scan_averager.sv | 45 ++++
 rtl/gradient_outlet_scanner.sv | 122 ++++++++++++
 3 files changed

// File: rtl/gradient_scan_pkg.sv
// Shared types and helpers for the gradient generator outlet scanner.
package gradient_scan_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    OUTPUT = 2'd3
  } scan_state_e;

  localparam int SEL_MAX_W = 32;

  // Callers truncate the result to their own outlet count.
  function automatic logic [SEL_MAX_W-1:0] onehot_sel(input logic [4:0] idx);
    logic [SEL_MAX_W-1:0] sel;
    sel      = '0;
    sel[idx] = 1'b1;
    return sel;
  endfunction

endpackage

// File: rtl/scan_averager.sv
// Sums 2**AVG_LOG2 detector samples for one outlet and presents the truncated mean.
module scan_averager
  import gradient_scan_pkg::*;
#(
  parameter int SAMPLE_W = 12,
  parameter int AVG_LOG2 = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                acc_en,
  input  logic [SAMPLE_W-1:0] smp_data,
  output logic                last_smp,
  output logic [SAMPLE_W-1:0] avg
);

  localparam int ACC_W = SAMPLE_W + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam int N_SMP = 1 << AVG_LOG2;

  logic [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;

  // The accumulator is wide enough for N_SMP full-scale samples, so the mean never wraps.
  function automatic logic [SAMPLE_W-1:0] avg_trunc(input logic [ACC_W-1:0] a);
    return SAMPLE_W'(a >> AVG_LOG2);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (clr) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (acc_en) begin
      acc_q <= acc_q + ACC_W'(smp_data);
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign last_smp = (cnt_q == CNT_W'(N_SMP - 1));
  assign avg      = avg_trunc(acc_q);

endmodule

// File: rtl/gradient_outlet_scanner.sv
// Steps the outlet selector valve across all outlets, settles, averages detector samples
// and streams one result per outlet.
module gradient_outlet_scanner
  import gradient_scan_pkg::*;
#(
  parameter  int N_OUT      = 7,
  parameter  int SAMPLE_W   = 12,
  parameter  int SETTLE_CYC = 16,
  parameter  int AVG_LOG2   = 2,
  localparam int IDX_W      = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  output logic [N_OUT-1:0]    valve_sel,
  output logic                smp_req,
  input  logic                smp_valid,
  input  logic [SAMPLE_W-1:0] smp_data,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [IDX_W-1:0]    res_idx,
  output logic [SAMPLE_W-1:0] res_data,
  output logic                busy,
  output logic                done
);

  localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC + 1) : 1;

  scan_state_e      state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [SET_W-1:0] settle_q, settle_d;
  logic             done_q, done_d;
  logic             acc_clr, acc_en, last_smp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      settle_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      settle_q <= settle_d;
      done_q   <= done_d;
    end
  end

  // abort is checked first in every active state so it beats both smp_valid and the handshake.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    settle_d  = settle_q;
    done_d    = 1'b0;
    acc_clr   = 1'b0;
    acc_en    = 1'b0;
    busy      = (state_q != IDLE);
    smp_req   = (state_q == SAMPLE);
    res_valid = (state_q == OUTPUT);
    valve_sel = busy ? N_OUT'(onehot_sel(5'(idx_q))) : '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          idx_d    = '0;
          settle_d = '0;
          state_d  = SETTLE;
        end
      end
      SETTLE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (settle_q == SET_W'(SETTLE_CYC - 1)) begin
          acc_clr = 1'b1;
          state_d = SAMPLE;
        end else begin
          settle_d = settle_q + SET_W'(1);
        end
      end
      SAMPLE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (smp_valid) begin
          acc_en = 1'b1;
          if (last_smp) state_d = OUTPUT;
        end
      end
      OUTPUT: begin
        if (abort) begin
          state_d = IDLE;
        end else if (res_ready) begin
          if (idx_q == IDX_W'(N_OUT - 1)) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            idx_d    = idx_q + IDX_W'(1);
            settle_d = '0;
            state_d  = SETTLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  scan_averager #(
    .SAMPLE_W (SAMPLE_W),
    .AVG_LOG2 (AVG_LOG2)
  ) u_avg (
    .clk      (clk),
    .rst      (rst),
    .clr      (acc_clr),
    .acc_en   (acc_en),
    .smp_data (smp_data),
    .last_smp (last_smp),
    .avg      (res_data)
  );

  assign res_idx = idx_q;
  assign done    = done_q;

endmodule
